cordic_result_buffer: RTL and testbench
=======================================

Name: cordic_result_buffer

Overview:
- Downstream consumer of the CORDIC wrapper's o_vld/o_data stream; the CORDIC output has no back-pressure.
- Strips the DATA_WIDTH bus to its OUTPUT_DATA_WIDTH payload and buffers results in a synchronous FIFO.
- Presents results on a valid/ready interface to the readout or scan logic.
- Counts results against a programmed frame length, raises done, and flags overflow when the FIFO is full and a result is lost.

Parameters:
- DATA_WIDTH, 56, width of incoming CORDIC bus.
- OUTPUT_DATA_WIDTH, 54, payload width kept (bits [OUTPUT_DATA_WIDTH-1:0] of i_data).
- FIFO_DEPTH, 8, entries; power of two, >=2.
- CNT_WIDTH, 16, width of frame length and result counter.

Ports:
- i_clk  input  1  clock; all state on rising edge.
- i_sync_rst  input  1  synchronous active-high reset.
- i_clear  input  1  synchronous soft clear (same effect as reset except no output glitch requirement).
- i_frame_len  input  CNT_WIDTH  results expected per frame; sampled on IDLE->COLLECT.
- i_vld  input  1  CORDIC result valid (connects to CORDIC o_vld).
- i_data  input  DATA_WIDTH  CORDIC result (connects to CORDIC o_data).
- o_vld  output  1  buffered result available.
- o_data  output  OUTPUT_DATA_WIDTH  FIFO head.
- i_rdy  input  1  consumer accepts o_data when o_vld&&i_rdy.
- o_level  output  $clog2(FIFO_DEPTH)+1  current occupancy.
- o_count  output  CNT_WIDTH  results accepted this frame.
- o_done  output  1  frame complete.
- o_overflow  output  1  sticky: result dropped.

Behaviour:
- Reset/clear (i_sync_rst or i_clear high at edge) makes the following zero next cycle: o_vld, o_level, o_count, o_done, o_overflow. FIFO pointers are zeroed and state is IDLE. i_sync_rst has priority over everything, including a simultaneous i_vld.
- Write: i_vld high and FIFO not full, or full with a pop in the same cycle, writes i_data[OUTPUT_DATA_WIDTH-1:0].
  - Write-through-when-full is allowed when pop and push coincide.
  - Push and pop together leave o_level unchanged.
- Drop: i_vld high, FIFO full, and no pop. The data is discarded, o_overflow is set (sticky until reset/clear), and o_count does not increment.
- Read: o_vld = (o_level != 0), registered. o_data is the FIFO head, valid the cycle o_vld is high and stable until the handshake. Latency from write to o_vld is 1 cycle (write at edge N gives o_vld high after edge N).
- Pointers wrap modulo FIFO_DEPTH. The full/empty distinction uses the level counter.
- FSM:
  - IDLE: on i_vld, latch i_frame_len into frame_len_q and go to COLLECT. That first result is written/counted.
  - COLLECT: o_count increments on each accepted write. When the increment makes o_count == frame_len_q, go to DONE.
  - DONE: o_done=1. Further i_vld is still buffered if there is space but is not counted. On i_clear go to IDLE.
- i_frame_len==0 at latch: go directly to DONE after the first write. That write is counted (o_count=1).
- o_count saturates at all-ones.
- Reset mid-frame discards FIFO contents and the count.

Optional Feature:
- Macro: CORDIC_RESULT_PARITY_EN.
- Defined:
  - Each FIFO entry stores an extra even-parity bit computed at write.
  - Extra output o_parity_err (1 bit) is high while o_vld and the recomputed parity of the head mismatches the stored bit.
  - Reset value 0.
- Undefined: no parity storage, port o_parity_err absent, FIFO width = OUTPUT_DATA_WIDTH.

Decomposition:
- Package cordic_pkg holds:
  - typedef enum logic [1:0] {ST_IDLE, ST_COLLECT, ST_DONE} buf_state_t.
  - localparams CORDIC_DATA_WIDTH=56 and CORDIC_OUT_WIDTH=54.
  - function even_parity.
- One sub-module, cordic_sync_fifo: parameterised width/depth, push/pop/full/empty/level, synchronous reset.
- cordic_result_buffer wraps it with the FSM, counter and overflow logic.

Test Plan:
- Reset, then i_frame_len=4 and 4 i_vld pulses with i_rdy=1 → 4 payloads in order, 1-cycle latency; o_count=4; o_done=1 after the 4th; o_overflow=0.
- i_rdy=0 with 9 back-to-back results, FIFO_DEPTH=8 → o_level=8; 9th dropped; o_overflow=1 sticky; o_count=8. Then i_rdy=1 drains exactly the first 8.
- FIFO full, i_vld and i_rdy in the same cycle → head popped, new data written, o_level stays 8, no overflow.
- i_frame_len=0 → after the first result o_done=1 and o_count=1. A later result is buffered but o_count stays 1.
- i_sync_rst asserted mid-frame with i_vld=1 and level 3 → next cycle o_vld=0, o_level=0, o_count=0, state IDLE, input not stored.
- With CORDIC_RESULT_PARITY_EN, force a bit flip in the stored head via hierarchical deposit → o_parity_err=1 while that entry is the head; clean entries → 0.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared types, widths and helpers for the CORDIC result buffer slice.
// Optional parity storage is selected with the CORDIC_RESULT_PARITY_EN macro.
package cordic_pkg;

    // Default widths of the CORDIC wrapper output bus and its payload
    localparam int CORDIC_DATA_WIDTH = 56;
    localparam int CORDIC_OUT_WIDTH  = 54;

    // Widest payload the parity helper accepts (payload is zero-extended)
    localparam int PARITY_MAX_W = 64;

    // Frame collection state
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } buf_state_t;

    // Even-parity bit: makes the total number of ones (data + bit) even.
    // Zero-extension of the argument does not change the result.
    function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/cordic_result_buffer_if.sv
// Stream bundle around the result buffer: the CORDIC result input
// (i_vld/i_data, no back-pressure) and the buffered readout output
// (o_vld/o_data/i_rdy).
//
// Handshake: the CORDIC side presents i_data whenever i_vld is high and
// cannot be stalled. On the readout side a word transfers on every rising
// edge where o_vld && i_rdy; o_data is held stable while o_vld is high and
// i_rdy is low, and o_vld never drops without a transfer except on
// reset/clear.
interface cordic_result_buffer_if
    import cordic_pkg::*;
#(
    parameter int DATA_WIDTH        = CORDIC_DATA_WIDTH,
    parameter int OUTPUT_DATA_WIDTH = CORDIC_OUT_WIDTH
);
    logic                         i_vld;
    logic [DATA_WIDTH-1:0]        i_data;
    logic                         o_vld;
    logic [OUTPUT_DATA_WIDTH-1:0] o_data;
    logic                         i_rdy;

    // Buffer side
    modport slave (
        input  i_vld,
        input  i_data,
        input  i_rdy,
        output o_vld,
        output o_data
    );

    // Producer / consumer side
    modport master (
        output i_vld,
        output i_data,
        output i_rdy,
        input  o_vld,
        input  o_data
    );
endinterface

// File: rtl/cordic_sync_fifo.sv
// Synchronous FIFO with a separate occupancy counter. Pointers wrap
// modulo DEPTH (power of two); full/empty come from the level counter.
// A push while full is accepted only when a pop happens in the same cycle.
module cordic_sync_fifo #(
    parameter int WIDTH = 54,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push, do_pop;

    assign empty = (level_q == '0);
    assign full  = (level_q == LW'(DEPTH));
    assign level = level_q;
    assign rdata = mem_q[rd_ptr_q];

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Next pointer and occupancy values
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointer and level registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage write; nothing is stored on the reset/clear cycle
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/cordic_result_buffer.sv
// CORDIC result buffer: strips the CORDIC bus to its payload, buffers it in
// a FIFO for a valid/ready consumer, counts results against a frame length,
// raises done at frame end and flags sticky overflow on dropped results.
// Define CORDIC_RESULT_PARITY_EN to store an even-parity bit per entry and
// expose o_parity_err.
module cordic_result_buffer
    import cordic_pkg::*;
#(
    parameter int DATA_WIDTH        = CORDIC_DATA_WIDTH,
    parameter int OUTPUT_DATA_WIDTH = CORDIC_OUT_WIDTH,
    parameter int FIFO_DEPTH        = 8,
    parameter int CNT_WIDTH         = 16
) (
    input  logic                           i_clk,
    input  logic                           i_sync_rst,
    input  logic                           i_clear,
    input  logic [CNT_WIDTH-1:0]           i_frame_len,
    cordic_result_buffer_if.slave          bus,
    output logic [$clog2(FIFO_DEPTH):0]    o_level,
    output logic [CNT_WIDTH-1:0]           o_count,
    output logic                           o_done,
    output logic                           o_overflow,
`ifdef CORDIC_RESULT_PARITY_EN
    output logic                           o_parity_err,
`endif
    output buf_state_t                     o_state
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
`ifdef CORDIC_RESULT_PARITY_EN
    localparam int FIFO_W = OUTPUT_DATA_WIDTH + 1;
`else
    localparam int FIFO_W = OUTPUT_DATA_WIDTH;
`endif

    logic                         rst_all;
    logic [OUTPUT_DATA_WIDTH-1:0] payload;
    logic [FIFO_W-1:0]            fifo_wdata, fifo_rdata;
    logic                         fifo_full, fifo_empty;
    logic [LW-1:0]                fifo_level;
    logic                         pop, push_ok, drop;
    logic                         unused_hi_bits;

    buf_state_t                   state_q, state_d;
    logic [CNT_WIDTH-1:0]         count_q, count_d;
    logic [CNT_WIDTH-1:0]         frame_len_q, frame_len_d;
    logic                         done_q, done_d;
    logic                         overflow_q, overflow_d;

    // Clear behaves exactly like reset for all buffer state
    assign rst_all = i_sync_rst || i_clear;

    // Bits above the payload are deliberately discarded
    assign payload        = bus.i_data[OUTPUT_DATA_WIDTH-1:0];
    assign unused_hi_bits = ^bus.i_data[DATA_WIDTH-1:OUTPUT_DATA_WIDTH];

    // A result is accepted if there is room, or room is made by a same-cycle pop
    assign pop     = bus.o_vld && bus.i_rdy;
    assign push_ok = bus.i_vld && (!fifo_full || pop);
    assign drop    = bus.i_vld && fifo_full && !pop;

`ifdef CORDIC_RESULT_PARITY_EN
    logic [PARITY_MAX_W-1:0] wr_ext, hd_ext;

    // Zero-extend write payload and head payload for the parity helper
    always_comb begin
        wr_ext = '0;
        hd_ext = '0;
        wr_ext[OUTPUT_DATA_WIDTH-1:0] = payload;
        hd_ext[OUTPUT_DATA_WIDTH-1:0] = fifo_rdata[OUTPUT_DATA_WIDTH-1:0];
    end

    assign fifo_wdata   = {even_parity(wr_ext), payload};
    assign o_parity_err = bus.o_vld &&
                          (even_parity(hd_ext) != fifo_rdata[OUTPUT_DATA_WIDTH]);
`else
    assign fifo_wdata = payload;
`endif

    cordic_sync_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (i_clk),
        .rst   (rst_all),
        .push  (bus.i_vld),
        .pop   (pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Level comes straight from the FIFO's registered counter
    assign bus.o_vld  = !fifo_empty;
    assign bus.o_data = fifo_rdata[OUTPUT_DATA_WIDTH-1:0];
    assign o_level    = fifo_level;
    assign o_count    = count_q;
    assign o_done     = done_q;
    assign o_overflow = overflow_q;
    assign o_state    = state_q;

    // Frame FSM next state, saturating result counter and sticky overflow
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        frame_len_d = frame_len_q;
        overflow_d  = overflow_q || drop;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_vld) begin
                    frame_len_d = i_frame_len;
                    state_d     = ST_COLLECT;
                    if (push_ok) begin
                        count_d = (count_q == '1) ? count_q : count_q + CNT_WIDTH'(1);
                        // A zero frame length completes on the first result
                        if (i_frame_len == '0 || count_d == i_frame_len) begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end
            ST_COLLECT: begin
                if (push_ok) begin
                    count_d = (count_q == '1) ? count_q : count_q + CNT_WIDTH'(1);
                    if (count_d == frame_len_q) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                // Results are still buffered by the FIFO but no longer counted
                state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
        done_d = (state_d == ST_DONE);
    end

    // Frame state registers; reset/clear returns to an empty IDLE frame
    always_ff @(posedge i_clk) begin
        if (rst_all) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            frame_len_q <= '0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            frame_len_q <= frame_len_d;
            done_q      <= done_d;
            overflow_q  <= overflow_d;
        end
    end

endmodule

// File: tb/tb_cordic_result_buffer.sv
// Directed bench for cordic_result_buffer. Build with
// CORDIC_RESULT_PARITY_EN defined to also exercise the parity output.
module tb_cordic_result_buffer;
    import cordic_pkg::*;

    typedef struct {
        logic        in_vld;
        logic [55:0] in_data;
        logic        in_rdy;
        logic        e_vld;
        logic [53:0] e_data;
        logic [3:0]  e_level;
        logic [15:0] e_count;
        logic        e_done;
        logic        e_ovf;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clr = 1'b0;
    logic [15:0] frame_len = '0;
    logic [3:0]  level;
    logic [15:0] count;
    logic        done, ovf;
    buf_state_t  state;
`ifdef CORDIC_RESULT_PARITY_EN
    logic        par_err;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [53:0] exp_q[$];

    cordic_result_buffer_if bus ();

    cordic_result_buffer dut (
        .i_clk        (clk),
        .i_sync_rst   (rst),
        .i_clear      (clr),
        .i_frame_len  (frame_len),
        .bus          (bus),
        .o_level      (level),
        .o_count      (count),
        .o_done       (done),
        .o_overflow   (ovf),
`ifdef CORDIC_RESULT_PARITY_EN
        .o_parity_err (par_err),
`endif
        .o_state      (state)
    );

    // Clock
    always #5 clk = ~clk;

    // Apply inputs, clock once, sample 1 time unit after the edge
    task automatic drive(input logic vld, input logic [55:0] data, input logic rdy);
        bus.i_vld  = vld;
        bus.i_data = data;
        bus.i_rdy  = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, '0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic chk_data(input string name, input logic [53:0] act, input logic [53:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_state(input string name, input buf_state_t exp);
        n_vec++;
        if (state !== exp) begin
            n_err++;
            $display("FAIL %s state: got %0d expected %0d", name, state, exp);
        end
    endtask

    // Compare every observable output against one expectation set
    task automatic chk_out(input string name, input logic e_vld, input logic [53:0] e_data,
                           input logic [3:0] e_level, input logic [15:0] e_count,
                           input logic e_done, input logic e_ovf);
        n_vec++;
        if (bus.o_vld !== e_vld) begin
            n_err++;
            $display("FAIL %s o_vld: got %0b expected %0b", name, bus.o_vld, e_vld);
        end
        if (e_vld) chk_data({name, " o_data"}, bus.o_data, e_data);
        n_vec++;
        if (level !== e_level) begin
            n_err++;
            $display("FAIL %s o_level: got %0d expected %0d", name, level, e_level);
        end
        n_vec++;
        if (count !== e_count) begin
            n_err++;
            $display("FAIL %s o_count: got %0d expected %0d", name, count, e_count);
        end
        chk_bit({name, " o_done"}, done, e_done);
        chk_bit({name, " o_overflow"}, ovf, e_ovf);
    endtask

    vec_t vecs[5];

    initial begin
        bus.i_vld  = 1'b0;
        bus.i_data = '0;
        bus.i_rdy  = 1'b0;

        // Basic frame of 4 with the consumer always ready
        vecs[0] = '{1'b1, 56'hC0_0000_0000_0001, 1'b1, 1'b1, 54'h00_0000_0000_0001, 4'd1, 16'd1, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 56'hFF_1234_5678_9ABC, 1'b1, 1'b1, 54'h3F_1234_5678_9ABC, 4'd1, 16'd2, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 56'h80_AAAA_5555_0F0F, 1'b1, 1'b1, 54'h00_AAAA_5555_0F0F, 4'd1, 16'd3, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 56'h7F_FFFF_FFFF_FFFF, 1'b1, 1'b1, 54'h3F_FFFF_FFFF_FFFF, 4'd1, 16'd4, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 56'h0,                 1'b1, 1'b0, 54'h0,                 4'd0, 16'd4, 1'b1, 1'b0};

        do_reset();
        chk_out("reset", 1'b0, '0, 4'd0, 16'd0, 1'b0, 1'b0);
        chk_state("reset", ST_IDLE);

        frame_len = 16'd4;
        for (int i = 0; i < 5; i++) begin
            drive(vecs[i].in_vld, vecs[i].in_data, vecs[i].in_rdy);
            // Frame length is latched only when the frame starts
            frame_len = 16'd2;
            chk_out($sformatf("frame4 v%0d", i), vecs[i].e_vld, vecs[i].e_data,
                    vecs[i].e_level, vecs[i].e_count, vecs[i].e_done, vecs[i].e_ovf);
        end
        chk_state("frame4 end", ST_DONE);

        // Overflow: 9 results into an 8-deep FIFO with no reads
        do_reset();
        frame_len = 16'd100;
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, {8'hA5, 48'(i)}, 1'b0);
            if (i < 8) begin
                exp_q.push_back({6'h25, 48'(i)});
                chk_out($sformatf("ovf fill %0d", i), 1'b1, {6'h25, 48'd0},
                        4'(i + 1), 16'(i + 1), 1'b0, 1'b0);
            end else begin
                chk_out("ovf drop", 1'b1, {6'h25, 48'd0}, 4'd8, 16'd8, 1'b0, 1'b1);
            end
        end
        for (int i = 0; i < 8; i++) begin
            bus.i_vld = 1'b0;
            chk_bit($sformatf("ovf drain vld %0d", i), bus.o_vld, 1'b1);
            chk_data($sformatf("ovf drain data %0d", i), bus.o_data, exp_q.pop_front());
            drive(1'b0, '0, 1'b1);
        end
        chk_out("ovf drained", 1'b0, '0, 4'd0, 16'd8, 1'b0, 1'b1);

        // Write-through when full
        do_reset();
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, {8'h3C, 48'(i + 16)}, 1'b0);
            exp_q.push_back({6'h3C, 48'(i + 16)});
        end
        drive(1'b1, {8'h3C, 48'h99}, 1'b1);
        void'(exp_q.pop_front());
        exp_q.push_back({6'h3C, 48'h99});
        chk_out("wt full", 1'b1, {6'h3C, 48'd17}, 4'd8, 16'd9, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            chk_data($sformatf("wt drain %0d", i), bus.o_data, exp_q.pop_front());
            drive(1'b0, '0, 1'b1);
        end
        chk_out("wt drained", 1'b0, '0, 4'd0, 16'd9, 1'b0, 1'b0);

        // Zero frame length finishes on the first result
        do_reset();
        frame_len = 16'd0;
        drive(1'b1, 56'hFF_1234_5678_9ABC, 1'b0);
        chk_out("len0 first", 1'b1, 54'h3F_1234_5678_9ABC, 4'd1, 16'd1, 1'b1, 1'b0);
        chk_state("len0 first", ST_DONE);
        drive(1'b1, 56'h80_AAAA_5555_0F0F, 1'b0);
        chk_out("len0 second", 1'b1, 54'h3F_1234_5678_9ABC, 4'd2, 16'd1, 1'b1, 1'b0);
        clr = 1'b1;
        drive(1'b0, '0, 1'b0);
        clr = 1'b0;
        chk_out("clear", 1'b0, '0, 4'd0, 16'd0, 1'b0, 1'b0);
        chk_state("clear", ST_IDLE);

        // Reset mid-frame with a coincident result
        frame_len = 16'd10;
        for (int i = 0; i < 3; i++) drive(1'b1, {8'h11, 48'(i)}, 1'b0);
        chk_out("mid fill", 1'b1, {6'h11, 48'd0}, 4'd3, 16'd3, 1'b0, 1'b0);
        rst = 1'b1;
        drive(1'b1, {8'h11, 48'h77}, 1'b0);
        rst = 1'b0;
        chk_out("mid reset", 1'b0, '0, 4'd0, 16'd0, 1'b0, 1'b0);
        chk_state("mid reset", ST_IDLE);
        drive(1'b0, '0, 1'b0);
        chk_out("mid idle", 1'b0, '0, 4'd0, 16'd0, 1'b0, 1'b0);
        frame_len = 16'd1;
        drive(1'b1, {8'h11, 48'h55}, 1'b0);
        chk_out("restart", 1'b1, {6'h11, 48'h55}, 4'd1, 16'd1, 1'b1, 1'b0);

`ifdef CORDIC_RESULT_PARITY_EN
        // Corrupt the stored head and check the parity flag
        do_reset();
        frame_len = 16'd10;
        chk_bit("par reset", par_err, 1'b0);
        drive(1'b1, 56'hFF_1234_5678_9ABC, 1'b0);
        drive(1'b1, 56'h80_AAAA_5555_0F0F, 1'b0);
        chk_bit("par clean", par_err, 1'b0);
        dut.u_fifo.mem_q[0][5] = ~dut.u_fifo.mem_q[0][5];
        #1;
        chk_bit("par flipped", par_err, 1'b1);
        drive(1'b0, '0, 1'b1);
        chk_bit("par next clean", par_err, 1'b0);
        chk_data("par next data", bus.o_data, 54'h00_AAAA_5555_0F0F);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
